ica_hmat_sched: RTL and testbench

//  Sequences one shared 16x32 MAC over the full 3x3 product H[i][j] = sum_k tanhu[i][k]*u[j][k], k = 0..63.
//  It replaces three parallel 64-wide dot-product engines with one time-multiplexed MAC.

---
 rtl/ica_hmat_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_ica_hmat_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ica_hmat_sched.sv
// ica_hmat_sched
//
// Purpose:
//   Computes the full N_COMP x N_COMP matrix H[i][j] = sum_k tanhu[i][k] * u[j][k]
//   over N_SAMP samples on one shared T_W x U_W multiply-accumulate unit.
//   The unit is time-multiplexed: one sample pair is read per cycle, k fastest,
//   then j, then i. Each finished dot product is written to the H register file.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active-low
//   start    begin a matrix computation (only looked at while idle)
//   abort    synchronous cancel of a running computation, flushes the pipeline
//   busy     high while reads are issued or the pipeline drains
//   done     one-cycle pulse one cycle after the last H write
//   rd_en    sample buffer read strobe
//   rd_i     tanhu row index
//   rd_j     u row index
//   rd_k     sample index
//   t_dat    tanhu[rd_i][rd_k], arrives one cycle after rd_en
//   u_dat    u[rd_j][rd_k], arrives one cycle after rd_en
//   h_we     H write strobe
//   h_wi     H row index of the write
//   h_wj     H column index of the write
//   h_wdat   completed dot product H[h_wi][h_wj]

module ica_hmat_sched #(
    parameter int N_COMP = 3,
    parameter int N_SAMP = 64,
    parameter int U_W    = 32,
    parameter int T_W    = 16,
    parameter int ACC_W  = 64,
    localparam int IW    = $clog2(N_COMP),
    localparam int KW    = $clog2(N_SAMP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [IW-1:0]         rd_i,
    output logic [IW-1:0]         rd_j,
    output logic [KW-1:0]         rd_k,
    input  logic [T_W-1:0]        t_dat,
    input  logic [U_W-1:0]        u_dat,
    output logic                  h_we,
    output logic [IW-1:0]         h_wi,
    output logic [IW-1:0]         h_wj,
    output logic [ACC_W-1:0]      h_wdat
);

    localparam int P_W = T_W + U_W;
    localparam logic [IW-1:0] I_MAX = IW'(N_COMP - 1);
    localparam logic [KW-1:0] K_MAX = KW'(N_SAMP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      drain_cnt;

    logic [IW-1:0]   cnt_i;
    logic [IW-1:0]   cnt_j;
    logic [KW-1:0]   cnt_k;
    logic            issue_last;
    logic            flush;

    // Stage 1: tags of the read issued last cycle; its data is on t_dat/u_dat now
    logic            s1_valid;
    logic            s1_first;
    logic            s1_last;
    logic [IW-1:0]   s1_i;
    logic [IW-1:0]   s1_j;

    // Stage 2: registered product and its tags
    logic            s2_valid;
    logic            s2_first;
    logic            s2_last;
    logic [IW-1:0]   s2_i;
    logic [IW-1:0]   s2_j;
    logic [P_W-1:0]  s2_prod;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_nxt;
    logic [P_W-1:0]   t_ext;
    logic [P_W-1:0]   u_ext;

    assign issue_last = (cnt_i == I_MAX) && (cnt_j == I_MAX) && (cnt_k == K_MAX);

    // An abort only matters while work is in flight; in IDLE and DONE it is ignored.
    assign flush = abort && ((state == S_RUN) || (state == S_DRAIN));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs. Abort takes priority over start in IDLE,
    // and the DRAIN phase covers the three pipeline stages behind the last issue.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_i      = '0;
        rd_j      = '0;
        rd_k      = '0;
        case (state)
            S_IDLE: begin
                if (!abort && start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                rd_i  = cnt_i;
                rd_j  = cnt_j;
                rd_k  = cnt_k;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (issue_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (drain_cnt == 2'd2) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counts the cycles spent in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if ((state == S_DRAIN) && !flush) begin
            drain_cnt <= drain_cnt + 2'd1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // Issue counters: k wraps into j, j wraps into i. They are parked at zero
    // outside RUN so every run starts at (0,0,0) and never steps past the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_i <= '0;
            cnt_j <= '0;
            cnt_k <= '0;
        end else if ((state != S_RUN) || flush || issue_last) begin
            cnt_i <= '0;
            cnt_j <= '0;
            cnt_k <= '0;
        end else if (cnt_k == K_MAX) begin
            cnt_k <= '0;
            if (cnt_j == I_MAX) begin
                cnt_j <= '0;
                cnt_i <= cnt_i + 1'b1;
            end else begin
                cnt_j <= cnt_j + 1'b1;
            end
        end else begin
            cnt_k <= cnt_k + 1'b1;
        end
    end

    // Sign extension of the operands so the multiply is signed at full product width,
    // and of the product to accumulator width.
    always_comb begin
        t_ext    = {{U_W{t_dat[T_W-1]}}, t_dat};
        u_ext    = {{T_W{u_dat[U_W-1]}}, u_dat};
        prod_ext = {{(ACC_W - P_W){s2_prod[P_W-1]}}, s2_prod};
        acc_nxt  = s2_first ? prod_ext : (acc + prod_ext);
    end

    // Stage 1 tags. The first/last flags mark the start and end of one dot product
    // so the accumulator restarts without a separate clear cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_i     <= '0;
            s1_j     <= '0;
        end else begin
            s1_valid <= rd_en && !flush;
            s1_first <= (cnt_k == '0);
            s1_last  <= (cnt_k == K_MAX);
            s1_i     <= cnt_i;
            s1_j     <= cnt_j;
        end
    end

    // Stage 2: product register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_i     <= '0;
            s2_j     <= '0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid && !flush;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_i     <= s1_i;
            s2_j     <= s1_j;
            s2_prod  <= $signed(t_ext) * $signed(u_ext);
        end
    end

    // Stage 3: accumulate, and on the last sample of an entry publish the sum.
    // The write port registers only change on a write so they hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            h_we   <= 1'b0;
            h_wi   <= '0;
            h_wj   <= '0;
            h_wdat <= '0;
        end else begin
            h_we <= s2_valid && s2_last && !flush;
            if (s2_valid && !flush) begin
                acc <= acc_nxt;
                if (s2_last) begin
                    h_wi   <= s2_i;
                    h_wj   <= s2_j;
                    h_wdat <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ica_hmat_sched.sv
// tb_ica_hmat_sched
//
// Purpose:
//   Self-checking bench for ica_hmat_sched. A sample buffer model answers reads
//   one cycle after rd_en; expected H entries come from a direct triple-loop sum
//   over the buffer contents, and expected timing from the run start cycle.
//
// Ports: none (top-level bench).

module tb_ica_hmat_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_i;
    logic [1:0]  rd_j;
    logic [5:0]  rd_k;
    logic [15:0] t_dat;
    logic [31:0] u_dat;
    logic        h_we;
    logic [1:0]  h_wi;
    logic [1:0]  h_wj;
    logic [63:0] h_wdat;

    logic signed [15:0] t_mem [0:2][0:63];
    logic signed [31:0] u_mem [0:2][0:63];
    longint             model_h [0:2][0:2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Monitor bookkeeping; only the monitor writes these, the main flow reads them.
    int rd_cnt    = 0;
    int rd_pos    = 0;
    int rd_first  = 0;
    int rd_last   = 0;
    int addr_err  = 0;
    int busy_cnt  = 0;
    int done_cnt  = 0;
    int hw_cnt    = 0;
    int hold_err  = 0;
    int done_cyc [0:31];
    int hw_cyc   [0:255];
    logic [1:0]         hw_i [0:255];
    logic [1:0]         hw_j [0:255];
    logic signed [63:0] hw_d [0:255];
    logic [1:0]  prev_wi  = '0;
    logic [1:0]  prev_wj  = '0;
    logic [63:0] prev_wd  = '0;
    logic        prev_rst = 1'b0;

    // Snapshots of the monitor counters at the start of each scenario.
    int b_rd, b_hw, b_done, b_busy, b_addr, b_hold;

    always #5 clk = ~clk;

    ica_hmat_sched dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .rd_en  (rd_en),
        .rd_i   (rd_i),
        .rd_j   (rd_j),
        .rd_k   (rd_k),
        .t_dat  (t_dat),
        .u_dat  (u_dat),
        .h_we   (h_we),
        .h_wi   (h_wi),
        .h_wj   (h_wj),
        .h_wdat (h_wdat)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Sample buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            t_dat <= t_mem[rd_i][rd_k];
            u_dat <= u_mem[rd_j][rd_k];
        end
    end

    // Monitor, sampled mid-cycle. The expected read address is derived from the
    // position within the current burst of consecutive reads.
    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_pos == 0) rd_first = cyc;
            if (rd_i !== 2'(rd_pos / 192) || rd_j !== 2'((rd_pos / 64) % 3) || rd_k !== 6'(rd_pos % 64))
                addr_err++;
            rd_pos++;
            rd_cnt++;
            rd_last = cyc;
        end else begin
            rd_pos = 0;
            if (rd_i !== 2'd0 || rd_j !== 2'd0 || rd_k !== 6'd0) addr_err++;
        end
        if (busy) busy_cnt++;
        if (done) begin
            if (done_cnt < 32) done_cyc[done_cnt] = cyc;
            done_cnt++;
        end
        if (h_we) begin
            if (hw_cnt < 256) begin
                hw_cyc[hw_cnt] = cyc;
                hw_i[hw_cnt]   = h_wi;
                hw_j[hw_cnt]   = h_wj;
                hw_d[hw_cnt]   = h_wdat;
            end
            hw_cnt++;
        end else if (rst && prev_rst &&
                     (h_wdat !== prev_wd || h_wi !== prev_wi || h_wj !== prev_wj)) begin
            hold_err++;
        end
        prev_wd  = h_wdat;
        prev_wi  = h_wi;
        prev_wj  = h_wj;
        prev_rst = rst;
    end

    // One comparison: counts it, and counts and reports a failure.
    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic takeSnap();
        b_rd   = rd_cnt;
        b_hw   = hw_cnt;
        b_done = done_cnt;
        b_busy = busy_cnt;
        b_addr = addr_err;
        b_hold = hold_err;
    endtask

    // Pulses start for one cycle and returns the cycle in which it is sampled.
    task automatic applyStimulus(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int n = 0; n < budget && done_cnt == b_done; n++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic computeModel();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                model_h[i][j] = 0;
                for (int k = 0; k < 64; k++)
                    model_h[i][j] += longint'(t_mem[i][k]) * longint'(u_mem[j][k]);
            end
    endtask

    task automatic fillConst(input logic signed [15:0] tv, input logic signed [31:0] uv);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 64; k++) begin
                t_mem[r][k] = tv;
                u_mem[r][k] = uv;
            end
        computeModel();
    endtask

    task automatic fillDistinct();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 64; k++) begin
                t_mem[r][k] = 16'(r + 1);
                u_mem[r][k] = 32'(k * (r + 1));
            end
        computeModel();
    endtask

    task automatic fillRandom();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 64; k++) begin
                t_mem[r][k] = 16'($urandom);
                u_mem[r][k] = 32'($urandom);
            end
        computeModel();
    endtask

    // Full-run checks against the model and the expected schedule.
    task automatic checkRun(input string name, input int t0);
        checkOutput({name, "_rd_count"}, rd_cnt - b_rd, 576);
        checkOutput({name, "_rd_first"}, rd_first, t0 + 1);
        checkOutput({name, "_rd_last"}, rd_last, t0 + 576);
        checkOutput({name, "_addr_order"}, addr_err - b_addr, 0);
        checkOutput({name, "_busy_cycles"}, busy_cnt - b_busy, 579);
        checkOutput({name, "_done_count"}, done_cnt - b_done, 1);
        checkOutput({name, "_done_cycle"}, done_cyc[b_done % 32], t0 + 580);
        checkOutput({name, "_hold"}, hold_err - b_hold, 0);
        checkOutput({name, "_hwe_count"}, hw_cnt - b_hw, 9);
        for (int n = 0; n < 9; n++) begin
            checkOutput($sformatf("%s_h%0d_i", name, n), hw_i[b_hw + n], n / 3);
            checkOutput($sformatf("%s_h%0d_j", name, n), hw_j[b_hw + n], n % 3);
            checkOutput($sformatf("%s_h%0d_data", name, n), hw_d[b_hw + n], model_h[n / 3][n % 3]);
            checkOutput($sformatf("%s_h%0d_cycle", name, n), hw_cyc[b_hw + n], t0 + 3 + 64 * (n + 1));
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        int t0;
        int s;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fillConst(16'sd0, 32'sd0);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {busy, done, rd_en, rd_i, rd_j, rd_k, h_we, h_wi, h_wj}, 0);
        checkOutput("reset_wdat", h_wdat, 0);
        #2 rst = 1'b1;

        // All ones
        fillConst(16'sd1, 32'sd1);
        takeSnap();
        applyStimulus(t0);
        checkOutput("ones_busy_after_start", busy, 1);
        waitDone(700);
        checkRun("ones", t0);
        checkOutput("ones_h22_const", hw_d[b_hw + 8], 64);

        // Extreme signed operands
        fillConst(-16'sd32768, 32'sh7fffffff);
        takeSnap();
        applyStimulus(t0);
        waitDone(700);
        checkRun("signed", t0);
        checkOutput("signed_h00_const", hw_d[b_hw], -(64'sd64 * 64'sd32768 * 64'sd2147483647));

        // Distinct rows
        fillDistinct();
        takeSnap();
        applyStimulus(t0);
        waitDone(700);
        checkRun("distinct", t0);
        checkOutput("distinct_h22_const", hw_d[b_hw + 8], 18144);
        checkOutput("distinct_h01_const", hw_d[b_hw + 1], 4032);

        // Random operands, two runs
        for (int r = 0; r < 2; r++) begin
            fillRandom();
            takeSnap();
            applyStimulus(t0);
            waitDone(700);
            checkRun($sformatf("random%0d", r), t0);
        end

        // Abort in the middle of a run, then restart
        fillRandom();
        takeSnap();
        applyStimulus(t0);
        while (cyc < t0 + 300) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (700) @(negedge clk);
        checkOutput("abort_rd_count", rd_cnt - b_rd, 300);
        checkOutput("abort_rd_last", rd_last, t0 + 300);
        checkOutput("abort_busy_cycles", busy_cnt - b_busy, 300);
        checkOutput("abort_hwe_count", hw_cnt - b_hw, 4);
        checkOutput("abort_done_count", done_cnt - b_done, 0);
        fillConst(16'sd1, 32'sd1);
        takeSnap();
        applyStimulus(t0);
        waitDone(700);
        checkRun("restart", t0);

        // Asynchronous reset in the middle of a run
        fillRandom();
        takeSnap();
        applyStimulus(t0);
        while (cyc < t0 + 200) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("midreset_ctrl", {busy, done, rd_en, rd_i, rd_j, rd_k, h_we, h_wi, h_wj}, 0);
        checkOutput("midreset_wdat", h_wdat, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        takeSnap();
        repeat (700) @(negedge clk);
        checkOutput("midreset_rd_count", rd_cnt - b_rd, 0);
        checkOutput("midreset_hwe_count", hw_cnt - b_hw, 0);
        checkOutput("midreset_done_count", done_cnt - b_done, 0);

        // start held high: one run per IDLE entry, start in busy/DONE ignored
        fillConst(16'sd1, 32'sd1);
        takeSnap();
        @(negedge clk);
        start = 1'b1;
        s     = cyc;
        repeat (1000) @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 1000 && done_cnt - b_done < 2; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("held_done_count", done_cnt - b_done, 2);
        checkOutput("held_done0_cycle", done_cyc[b_done % 32], s + 580);
        checkOutput("held_done1_cycle", done_cyc[(b_done + 1) % 32], s + 1161);
        checkOutput("held_rd_count", rd_cnt - b_rd, 1152);
        checkOutput("held_hwe_count", hw_cnt - b_hw, 18);
        checkOutput("held_addr_order", addr_err - b_addr, 0);
        for (int n = 0; n < 18; n++)
            checkOutput($sformatf("held_h%0d_data", n), hw_d[b_hw + n], 64);

        // abort and start together in IDLE: nothing happens
        takeSnap();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abortstart_rd_count", rd_cnt - b_rd, 0);
        checkOutput("abortstart_busy_cycles", busy_cnt - b_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
